bcd2bin: RTL and testbench
==========================

# bcd2bin

Sequential BCD-to-binary converter: the reverse of the combinational binary-to-BCD path, used to turn operator- or display-side decimal values back into binary for the arithmetic datapath. It accepts an N-digit packed BCD word on a start/ready handshake and runs a reverse double-dabble engine, one bit per cycle. It returns the W-bit binary result with a one-cycle done pulse. An optional digit checker flags non-decimal digits.

## Interface
Parameters:
- N — 6 — number of BCD digits.
- W — 20 — binary output width. Constraint: 2^W > 10^N − 1. The default covers 999999.

Ports (one clock, `clk`; reset `reset` is synchronous and active-high):
- clk — in — 1 — rising-edge clock.
- reset — in — 1 — synchronous, active-high reset.
- start — in — 1 — request conversion; honoured only while ready=1.
- bcd_in — in — 4N — packed BCD input, digit 0 in [3:0].
- ready — out — 1 — engine idle, may accept start.
- done_tick — out — 1 — one-cycle pulse, result valid.
- bin — out — W — binary result; held until the next done_tick.
- err — out — 1 — invalid-digit flag, qualified by done_tick.

## Operation
- States: IDLE, OP, DONE.
- **IDLE**
  - ready=1.
  - On start=1: bcd_reg←bcd_in, bin_reg←0, n←W−1, go to OP.
- **OP**, one step per cycle:
  - Shift the concatenation {bcd_reg, bin_reg} right by 1 bit.
  - Then, for each 4-bit digit of the shifted bcd_reg: if the digit is ≥ 8, subtract 3. Adjust is applied to all digits in parallel, same cycle.
  - If n=0, go to DONE; else n←n−1.
- **DONE**
  - done_tick=1.
  - bin←bin_reg (register update at this cycle's edge; bin reflects the new value from the next cycle).
  - Go to IDLE.
- start is ignored outside IDLE; there is no queuing.
- bin holds its value across IDLE/OP until the next DONE.
- Arithmetic: n is ceil(log2(W)) bits. Digit subtract is 4-bit modulo. Residue in bcd_reg after W steps is 0 for all legal inputs.

## Timing
- **Reset values:** state=IDLE, ready=1, done_tick=0, bin=0, err=0, internal registers 0.
- **Latency:**
  - start sampled at edge k → OP during cycles k+1 … k+W.
  - DONE during cycle k+W+1: done_tick=1 in that cycle, bin updated at the end of that cycle.
  - ready=1 again from cycle k+W+2.
- **Throughput:** one conversion per W+2 cycles. Back-to-back starts are accepted on the first ready cycle.
- start held high continuously restarts immediately after each DONE.
- **Reset mid-operation:** abort, all reset values restored at the next edge, no done_tick.
- bcd_in is sampled only at the accepting edge; later changes have no effect.

## Configuration
- **Macro `BCD2BIN_CHECK_EN` defined:**
  - At the accepting edge, latch err_reg = OR over digits of (digit > 9).
  - In DONE: err←err_reg. If err_reg=1, bin←0 instead of bin_reg.
  - Conversion timing is unchanged.
- **Undefined:**
  - err is constant 0.
  - Invalid digits are converted without a check; the result is deterministic but unspecified.

## Structure
- **Package `bcd_pkg`:**
  - `typedef enum logic [1:0] {IDLE, OP, DONE} bcd2bin_state_t`
  - localparam BCD_DIG_W=4
  - localparam BCD_ADJ_THRESH=8
- **Sub-module `bcd_digit_adj`:** combinational 4-bit cell. Output = (d ≥ 8) ? d−3 : d. Instantiated N times with generate.
- The top holds the FSM, the counter and the shift registers.

## Test plan
- **Reset then idle:** reset=1 for 2 cycles → ready=1, bin=0, done_tick=0, err=0.
- **Basic values:** bcd_in=0x123456, start pulse → done_tick exactly 21 cycles after the accepting edge (W+1), bin=0x1E240. Also 0x000000 → 0; 0x000009 → 9.
- **Maximum:** bcd_in=0x999999 → bin=0x0F423F. Start held high for 3 conversions → done_tick every 22 cycles, every result correct.
- **Busy/handshake:**
  - start pulsed in OP with bcd_in=0x000001 → ignored; the original result is unaffected.
  - bcd_in changed after the accept edge → the result reflects the sampled value.
- **Reset mid-operation:** reset at cycle 10 of OP → no done_tick, bin=0. A following conversion of 0x000042 → bin=42.
- **Invalid digit (`BCD2BIN_CHECK_EN`):** bcd_in=0x00000A → err=1, bin=0 at done_tick. The next legal 0x000010 → err=0, bin=10.

Source files
------------

// File: rtl/bcd_pkg.sv
//============================================================================
// Module   : bcd_pkg
// Purpose  : Shared types and constants for the BCD-to-binary converter.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package bcd_pkg;

    localparam int BCD_DIG_W      = 4;
    localparam int BCD_ADJ_THRESH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } bcd2bin_state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
//============================================================================
// Module   : bcd_digit_adj
// Purpose  : Reverse double-dabble digit correction. A digit that reaches 8
//            or more after the right shift carried in a bit worth 8 that
//            should only be worth 5 (10/2), so 3 is removed.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIG_W-1:0] d,
    output logic [BCD_DIG_W-1:0] q
);

    localparam logic [BCD_DIG_W-1:0] C_THRESH = BCD_DIG_W'(BCD_ADJ_THRESH);
    localparam logic [BCD_DIG_W-1:0] C_ADJ    = BCD_DIG_W'(3);

    assign q = (d >= C_THRESH) ? (d - C_ADJ) : d;

endmodule

`default_nettype wire

// File: rtl/bcd2bin.sv
//============================================================================
// Module   : bcd2bin
// Purpose  : Sequential N-digit BCD to W-bit binary converter. One shift of
//            the reverse double-dabble engine per clock, W shifts per
//            conversion, start/ready handshake and a one-cycle done pulse.
// Options  : BCD2BIN_CHECK_EN - when defined, non-decimal input digits are
//            flagged on err and the result is forced to zero.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module bcd2bin
    import bcd_pkg::*;
#(
    parameter int N = 6,
    parameter int W = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BCD_DIG_W*N-1:0] bcd_in,
    output logic                   ready,
    output logic                   done_tick,
    output logic [W-1:0]           bin,
    output logic                   err
);

    localparam int BW    = BCD_DIG_W * N;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(W - 1);

    bcd2bin_state_t   r_state;
    logic [BW-1:0]    r_bcd;
    logic [W-1:0]     r_bin;
    logic [CNT_W-1:0] r_cnt;

    logic [BW-1:0]    w_bcd_sh;
    logic [W-1:0]     w_bin_sh;
    logic [BW-1:0]    w_bcd_adj;

    // The BCD LSB falls into the binary MSB on every right shift.
    assign w_bcd_sh = {1'b0, r_bcd[BW-1:1]};
    assign w_bin_sh = {r_bcd[0], r_bin[W-1:1]};

    for (genvar i = 0; i < N; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (w_bcd_sh[i*BCD_DIG_W +: BCD_DIG_W]),
            .q (w_bcd_adj[i*BCD_DIG_W +: BCD_DIG_W])
        );
    end

`ifdef BCD2BIN_CHECK_EN
    logic [N-1:0] w_dig_bad;
    logic         r_err_lat;

    for (genvar i = 0; i < N; i++) begin : g_chk
        assign w_dig_bad[i] = (bcd_in[i*BCD_DIG_W +: BCD_DIG_W] > BCD_DIG_W'(9));
    end

    // Invalid-digit flag captured at accept and published with the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_lat <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_err_lat <= |w_dig_bad;
            end
            if (r_state == DONE) begin
                err <= r_err_lat;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

    // Control FSM, step counter, shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            ready     <= 1'b1;
            done_tick <= 1'b0;
            bin       <= '0;
        end else begin
            done_tick <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bcd   <= bcd_in;
                        r_bin   <= '0;
                        r_cnt   <= C_LAST;
                        ready   <= 1'b0;
                        r_state <= OP;
                    end
                end
                OP: begin
                    r_bcd <= w_bcd_adj;
                    r_bin <= w_bin_sh;
                    if (r_cnt == '0) begin
                        // Raise the pulse on the edge entering DONE so it
                        // is high for exactly the DONE cycle.
                        done_tick <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
`ifdef BCD2BIN_CHECK_EN
                    bin <= r_err_lat ? '0 : r_bin;
`else
                    bin <= r_bin;
`endif
                    ready   <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    ready   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd2bin.sv
//============================================================================
// Module   : tb_bcd2bin
// Purpose  : Self-checking bench for bcd2bin: vector table plus handshake,
//            back-to-back, mid-conversion reset and digit-check sequences.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_bcd2bin;

    localparam int N  = 6;
    localparam int W  = 20;
    localparam int BW = 4 * N;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [BW-1:0] bcd_in;
    logic          ready;
    logic          done_tick;
    logic [W-1:0]  bin;
    logic          err;

    bcd2bin #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bcd_in    (bcd_in),
        .ready     (ready),
        .done_tick (done_tick),
        .bin       (bin),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [BW-1:0] bcd;
        logic [W-1:0]  exp_bin;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [W-1:0] bin;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent decimal model: weight each digit by its power of ten.
    function automatic logic [W-1:0] bcd_val(input logic [BW-1:0] b);
        int v;
        v = 0;
        for (int i = N - 1; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
        return W'(v);
    endfunction

    // Result monitor: bin/err are checked the cycle after done_tick.
    always @(negedge clk) begin
        if (chk_pending) begin
            exp_t e;
            chk_pending = 1'b0;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done_tick with bin=0x%0h, expected no result", bin);
            end else begin
                e = sb.pop_front();
                check("bin", 32'(bin), 32'(e.bin));
                check("err", 32'(err), 32'(e.err));
            end
        end
        if (done_tick === 1'b1) chk_pending = 1'b1;
    end

    // Called at a negedge; returns at the negedge where ready is seen high.
    task automatic wait_ready();
        int t;
        t = 0;
        while (ready !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: ready=%b, expected 1 within 60 cycles", ready);
        end
    endtask

    // Called right after the accepting posedge; counts cycles to done_tick.
    task automatic wait_done(output int lat, input bit drop_start);
        @(negedge clk);
        if (drop_start) start = 1'b0;
        lat = 1;
        while (done_tick !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic convert(input logic [BW-1:0] b, input logic [W-1:0] eb, input logic ee);
        int lat;
        wait_ready();
        start  = 1'b1;
        bcd_in = b;
        @(posedge clk);
        sb.push_back('{bin: eb, err: ee});
        wait_done(lat, 1'b1);
        check("latency", 32'(lat), 32'(W + 1));
        @(negedge clk);
    endtask

    vec_t tv[8];
    int   done_cyc[3];

    initial begin
        logic [BW-1:0] rb;
        int lat;

        tv[0] = '{24'h123456, 20'h1E240, 1'b0};
        tv[1] = '{24'h000000, 20'h00000, 1'b0};
        tv[2] = '{24'h000009, 20'h00009, 1'b0};
        tv[3] = '{24'h999999, 20'hF423F, 1'b0};
        tv[4] = '{24'h000100, 20'h00064, 1'b0};
        tv[5] = '{24'h500000, 20'h7A120, 1'b0};
        tv[6] = '{24'h010203, 20'h027DB, 1'b0};
        tv[7] = '{24'h000042, 20'h0002A, 1'b0};

        reset  = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_bin", 32'(bin), 32'd0);
        check("rst_done", 32'(done_tick), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) convert(tv[i].bcd, tv[i].exp_bin, tv[i].exp_err);

        for (int i = 0; i < 4; i++) begin
            for (int d = 0; d < N; d++) rb[d*4 +: 4] = 4'($urandom_range(0, 9));
            convert(rb, bcd_val(rb), 1'b0);
        end

        // Start held high: three conversions on consecutive ready cycles.
        start  = 1'b1;
        bcd_in = 24'h999999;
        for (int i = 0; i < 3; i++) begin
            wait_ready();
            @(posedge clk);
            sb.push_back('{bin: 20'hF423F, err: 1'b0});
            wait_done(lat, i == 2);
            check("hold_latency", 32'(lat), 32'(W + 1));
            done_cyc[i] = cyc;
        end
        @(negedge clk);
        check("hold_period1", 32'(done_cyc[1] - done_cyc[0]), 32'(W + 2));
        check("hold_period2", 32'(done_cyc[2] - done_cyc[1]), 32'(W + 2));

        // Start during OP is ignored; bcd_in changes after accept are ignored.
        wait_ready();
        start  = 1'b1;
        bcd_in = 24'h123456;
        @(posedge clk);
        sb.push_back('{bin: 20'h1E240, err: 1'b0});
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 24'h000777;
        repeat (4) @(negedge clk);
        check("busy_ready", 32'(ready), 32'd0);
        start  = 1'b1;
        bcd_in = 24'h000001;
        @(negedge clk);
        start  = 1'b0;
        lat = 0;
        while (done_tick !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("busy_done_seen", 32'(done_tick), 32'd1);
        repeat (30) @(negedge clk);

        // Reset during OP cycle 10: aborted, no result.
        wait_ready();
        start  = 1'b1;
        bcd_in = 24'h123456;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_bin", 32'(bin), 32'd0);
        check("abort_done", 32'(done_tick), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        repeat (30) @(negedge clk);
        check("abort_bin_held", 32'(bin), 32'd0);
        convert(24'h000042, 20'd42, 1'b0);

`ifdef BCD2BIN_CHECK_EN
        convert(24'h00000A, 20'd0, 1'b1);
        convert(24'h000010, 20'd10, 1'b0);
`else
        convert(24'h000010, 20'd10, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
